// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared defaults and frame FSM states for the I2S transmitter
package i2s_tx_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_SCLK_HALF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    PAD
  } state_t;

endpackage

// File: rtl/i2s_bitclk.sv
// rtl/i2s_bitclk.sv - free-running sclk divider with synchronous restart
module i2s_bitclk
  import i2s_tx_pkg::*;
#(
  parameter int SCLK_HALF = DEFAULT_SCLK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic sclk,
  output logic fall
);

  localparam int CW = $clog2(SCLK_HALF);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(SCLK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Flags the cycle whose clock edge takes sclk from 1 to 0; a restart overrides it.
  assign fall = sclk & wrap & ~restart;

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S stereo transmitter: lrck edge detect, one-pair holding register, shift FSM
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SCLK_HALF = DEFAULT_SCLK_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lrck,
  input  logic [WIDTH-1:0] l_data,
  input  logic [WIDTH-1:0] r_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             lrck_out,
  output logic             underrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             lrck_q;
  logic             edge_det;
  logic             left_start;
  logic             right_start;
  logic             fall;
  logic             restart;

  logic             hold_full;
  logic [WIDTH-1:0] l_hold;
  logic [WIDTH-1:0] r_hold;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  // lrck_q tracks lrck even in reset so release never shows a phantom edge.
  always_ff @(posedge clk) begin
    lrck_q <= lrck;
  end

  assign edge_det    = lrck ^ lrck_q;
  assign left_start  = edge_det & ~lrck;
  assign right_start = edge_det & lrck;
  assign restart     = edge_det | (state_q == IDLE);

  i2s_bitclk #(
    .SCLK_HALF(SCLK_HALF)
  ) u_bitclk (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .sclk   (sclk),
    .fall   (fall)
  );

  assign in_ready = ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      l_hold    <= '0;
      r_hold    <= '0;
    end else if (in_valid && !hold_full) begin
      hold_full <= 1'b1;
      l_hold    <= l_data;
      r_hold    <= r_data;
    end else if (left_start && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    if (edge_det) begin
      // Any lrck edge aborts whatever is in flight and re-arms the one-bit delay.
      state_d   = WAIT;
      bit_cnt_d = '0;
      sdata_d   = 1'b0;
      if (left_start) begin
        if (hold_full) begin
          shift_d = l_hold;
          pend_d  = r_hold;
        end else begin
          shift_d    = '0;
          pend_d     = '0;
          underrun_d = 1'b1;
        end
      end else if (right_start) begin
        shift_d = pend_q;
      end
    end else if (fall) begin
      case (state_q)
        WAIT: begin
          sdata_d   = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt_q == CNT_W'(WIDTH)) begin
            sdata_d = 1'b0;
            state_d = PAD;
          end else begin
            sdata_d   = shift_q[WIDTH-1];
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PAD:     sdata_d = 1'b0;
        default: sdata_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pend_q     <= '0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign sdata    = sdata_q;
  assign lrck_out = lrck_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized self-checking bench for i2s_tx against a frame-timing reference model
module tb_i2s_tx;

  localparam int W = 16;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         lrck;
  logic         in_valid;
  logic [W-1:0] l_data;
  logic [W-1:0] r_data;
  logic         in_ready;
  logic         sclk;
  logic         sdata;
  logic         lrck_out;
  logic         underrun;

  always #5 clk = ~clk;

  i2s_tx #(
    .WIDTH    (W),
    .SCLK_HALF(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lrck    (lrck),
    .l_data  (l_data),
    .r_data  (r_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sclk    (sclk),
    .sdata   (sdata),
    .lrck_out(lrck_out),
    .underrun(underrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: frame content and sclk/sdata timing derived from the edge cycle.
  int           cyc = 0;
  int           m_e = 0;
  bit           m_in_frame = 0;
  logic         m_lr_prev = 1'b1;
  bit           m_hold = 0;
  bit           m_und = 0;
  logic [W-1:0] m_fw = '0, m_pend = '0, m_hl = '0, m_hr = '0;

  logic         sclk_prev = 1'b0;
  logic [31:0]  cap = '0;
  int           rises = 0;
  int           und_cnt = 0;
  logic         cur_lr = 1'b1;

  task automatic step(input logic rs, input logic lr, input logic v,
                      input logic [W-1:0] l, input logic [W-1:0] r);
    bit old_hold;
    int d, k;
    logic exp_sclk, exp_sdata;
    rst = rs; lrck = lr; in_valid = v; l_data = l; r_data = r;
    if (rs) begin
      m_in_frame = 0; m_hold = 0; m_und = 0;
      m_fw = '0; m_pend = '0; m_hl = '0; m_hr = '0;
    end else begin
      old_hold = m_hold;
      m_und    = 0;
      if (lr != m_lr_prev) begin
        m_in_frame = 1;
        m_e        = cyc;
        if (!lr) begin
          if (old_hold) begin
            m_fw = m_hl; m_pend = m_hr; m_hold = 0;
          end else begin
            m_fw = '0; m_pend = '0; m_und = 1;
          end
        end else begin
          m_fw = m_pend;
        end
      end
      if (v && !old_hold) begin
        m_hold = 1; m_hl = l; m_hr = r;
      end
    end
    m_lr_prev = lr;
    cyc++;
    @(posedge clk);
    #1;
    exp_sclk  = 1'b0;
    exp_sdata = 1'b0;
    if (m_in_frame) begin
      d        = cyc - m_e;
      exp_sclk = (((d - 1) / H) % 2) != 0;
      if (d >= 2 * H + 1) begin
        k = (d - 2 * H - 1) / (2 * H);
        if (k < W) exp_sdata = m_fw[W-1-k];
      end
    end
    check("sclk", sclk, exp_sclk);
    check("sdata", sdata, exp_sdata);
    check("underrun", underrun, m_und);
    check("in_ready", in_ready, !m_hold);
    check("lrck_out", lrck_out, lr);
    if (sclk && !sclk_prev) begin
      cap = {cap[30:0], sdata};
      rises++;
    end
    sclk_prev = sclk;
    if (underrun) und_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_lr, 1'b0, '0, '0);
  endtask

  task automatic frame(input logic lr, input int len, input logic v0,
                       input logic [W-1:0] l, input logic [W-1:0] r);
    cur_lr = lr;
    cap    = '0;
    rises  = 0;
    step(1'b0, lr, v0, l, r);
    for (int i = 1; i < len; i++) step(1'b0, lr, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    check("rdy_post_rst", in_ready, 1'b1);
    und_cnt = 0;
    idle(10);
    check("idle_no_und", und_cnt, 0);

    // Pair held before the left edge
    step(1'b0, 1'b1, 1'b1, 16'hA5C3, 16'h0F01);
    idle(3);
    frame(1'b0, 80, 1'b0, '0, '0);
    check("rise_cnt", rises, 20);
    check("delay_bit", cap[19], 1'b0);
    check("left_word", cap[18:3], 16'hA5C3);
    frame(1'b1, 80, 1'b0, '0, '0);
    check("right_word", cap[18:3], 16'h0F01);
    check("no_und", und_cnt, 0);

    // Nothing held at the left edge
    frame(1'b0, 80, 1'b0, '0, '0);
    check("und_once", und_cnt, 1);
    check("left_zero", cap, 32'h0);
    frame(1'b1, 80, 1'b0, '0, '0);
    check("right_zero", cap, 32'h0);

    // Pair offered on the very edge cycle goes to the following left frame
    und_cnt = 0;
    frame(1'b0, 80, 1'b1, 16'h1234, 16'hABCD);
    check("edge_und", und_cnt, 1);
    check("edge_left_zero", cap, 32'h0);
    frame(1'b1, 80, 1'b0, '0, '0);
    frame(1'b0, 80, 1'b0, '0, '0);
    check("late_left", cap[18:3], 16'h1234);
    frame(1'b1, 80, 1'b0, '0, '0);
    check("late_right", cap[18:3], 16'hABCD);

    // Short frames truncate the word
    step(1'b0, cur_lr, 1'b1, 16'h3C5A, 16'h9669);
    frame(1'b0, 40, 1'b0, '0, '0);
    check("trunc_delay", cap[9], 1'b0);
    check("trunc_hi8", cap[8:1], 8'h3C);
    frame(1'b1, 40, 1'b0, '0, '0);
    check("trunc_r_delay", cap[9], 1'b0);
    check("trunc_r_hi8", cap[8:1], 8'h96);

    // Reset in mid-shift drops the held pair
    step(1'b0, cur_lr, 1'b1, 16'hFFFF, 16'hFFFF);
    frame(1'b0, 20, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hCAFE);
    idle(4);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    cur_lr = 1'b0;
    idle(10);
    und_cnt = 0;
    frame(1'b1, 80, 1'b0, '0, '0);
    check("post_rst_right", cap, 32'h0);
    frame(1'b0, 80, 1'b0, '0, '0);
    check("dropped_pair", cap, 32'h0);
    check("dropped_und", und_cnt, 1);

    // Randomized frames and producer traffic
    for (int f = 0; f < 30; f++) begin
      int len;
      len    = $urandom_range(36, 90);
      cur_lr = ~cur_lr;
      for (int i = 0; i < len; i++)
        step(1'b0, cur_lr, ($urandom_range(0, 5) == 0), W'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
